// File: rtl/ibex_prefetch_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ibex_prefetch_req_ctrl_pkg
//
// Shared constants for the instruction prefetch request controller.
//
// Contents:
//   NUM_REQS_DEFAULT  default number of outstanding bus transactions. It must
//                     match the NUM_REQS of the downstream fetch FIFO.
//   WORD_ADDR_W       width of a word address (byte address bits [31:2]).
// -----------------------------------------------------------------------------
package ibex_prefetch_req_ctrl_pkg;

    localparam int unsigned NUM_REQS_DEFAULT = 2;
    localparam int unsigned WORD_ADDR_W      = 30;

endpackage : ibex_prefetch_req_ctrl_pkg

// File: rtl/ibex_prefetch_req_ctrl.sv
// -----------------------------------------------------------------------------
// ibex_prefetch_req_ctrl
//
// Instruction-side bus master that feeds ibex_fetch_fifo. It issues
// word-aligned fetch requests and keeps up to NUM_REQS transactions in flight.
// A branch discards any responses that are still outstanding. Responses that
// are kept pass straight through to the FIFO. On a branch the FIFO also gets
// its clear strobe and its new start address.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i               core wants instructions; low blocks new bus requests
//   branch_i, addr_i    redirect fetch to addr_i this cycle
//   busy_o              a transaction is outstanding or a request is up
//   instr_req_o/gnt_i   bus request / grant
//   instr_addr_o        bus word address (bits [1:0] = 0)
//   instr_rvalid_i      bus response valid (responses return in order)
//   instr_rdata_i/err_i bus response data / error
//   fifo_busy_i         FIFO slot occupancy
//   fifo_clear_o        FIFO clear (same cycle as branch_i)
//   fifo_addr_o         FIFO start address (used only together with clear)
//   fifo_valid_o        push the current response into the FIFO
//   fifo_rdata_o/err_o  pushed data / error
// -----------------------------------------------------------------------------
module ibex_prefetch_req_ctrl
    import ibex_prefetch_req_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQS = NUM_REQS_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o
);

    // Thermometer of outstanding transactions (bit 0 = oldest) and the matching
    // per-slot discard flags.
    logic [NUM_REQS-1:0]    out_q, out_d, out_shift;
    logic [NUM_REQS-1:0]    disc_q, disc_d, disc_shift;
    logic [WORD_ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic                   req_pending_q, req_pending_d;

    logic fifo_space;
    logic new_req;
    logic gnt;
    logic rsp;

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    // A free FIFO slot must exist that is not already reserved by a bus
    // transaction in flight. A branch bypasses this check because the FIFO is
    // cleared in the same cycle.
    assign fifo_space = ~&(fifo_busy_i | out_q);

    // Once a request is up it stays up until it is granted.
    assign new_req = (req_i & (fifo_space | branch_i) & ~out_q[NUM_REQS-1])
                   | req_pending_q;

    // The request path is combinational from req_i, so it is masked while
    // reset is high. Without the mask the bus would see a request while the
    // controller state is held cleared.
    assign instr_req_o = new_req & ~rst_i;

    // An ungranted request may change address only because of a branch.
    assign instr_addr_o = branch_i ? {addr_i[31:2], 2'b00} : {fetch_addr_q, 2'b00};

    assign gnt = instr_req_o & instr_gnt_i;

    // -------------------------------------------------------------------------
    // Response side
    // -------------------------------------------------------------------------
    // A response counts only if a transaction is outstanding. After a reset,
    // responses to transactions from before the reset are ignored.
    assign rsp = instr_rvalid_i & out_q[0];

    // A response in the branch cycle is dropped because the FIFO is clearing.
    assign fifo_valid_o = rsp & ~disc_q[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;

    assign busy_o = (|out_q) | instr_req_o;

    // -------------------------------------------------------------------------
    // Outstanding / discard shift register
    // A response shifts every slot down first. A grant then occupies the
    // lowest free slot, so a grant and a response together leave the count
    // unchanged. A branch marks every slot that survives the shift. The slot
    // granted in the branch cycle belongs to the new stream and is kept.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
        logic below_full;

        if (i == NUM_REQS - 1) begin : g_top
            assign out_shift[i]  = rsp ? 1'b0 : out_q[i];
            assign disc_shift[i] = rsp ? 1'b0 : disc_q[i];
        end else begin : g_mid
            assign out_shift[i]  = rsp ? out_q[i+1]  : out_q[i];
            assign disc_shift[i] = rsp ? disc_q[i+1] : disc_q[i];
        end

        if (i == 0) begin : g_base
            assign below_full = 1'b1;
        end else begin : g_upper
            assign below_full = out_shift[i-1];
        end

        assign out_d[i]  = out_shift[i] | (gnt & below_full);
        assign disc_d[i] = out_shift[i] & (disc_shift[i] | branch_i);
    end

    // -------------------------------------------------------------------------
    // Fetch address and pending-request next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path can leave it unassigned and infer a latch.
        fetch_addr_d  = fetch_addr_q;
        req_pending_d = instr_req_o & ~instr_gnt_i;

        if (branch_i) begin
            fetch_addr_d = addr_i[31:2];
        end
        if (gnt) begin
            fetch_addr_d = instr_addr_o[31:2] + 30'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q         <= '0;
            disc_q        <= '0;
            fetch_addr_q  <= '0;
            req_pending_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            disc_q        <= disc_d;
            fetch_addr_q  <= fetch_addr_d;
            req_pending_q <= req_pending_d;
        end
    end

    // A bus response is legal only when a transaction is outstanding.
    rvalid_without_outstanding : assert property (
        @(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> out_q[0]
    ) else $error("instr_rvalid_i with no outstanding transaction");

endmodule : ibex_prefetch_req_ctrl
